// File: rtl/prng_pkg.sv
// prng_pkg -- constants, state encoding and seed helpers shared by prng_arbiter (rev 1.0)
`default_nettype none

package prng_pkg;

  localparam int          NREQ_MAX   = 8;
  localparam logic [31:0] PM_MODULUS = 32'h7FFF_FFFF;
  localparam logic [31:0] PM_A       = 32'd16807;

  localparam logic [31:0] DEFAULT_SEEDS [NREQ_MAX] = '{
    32'd5, 32'd7, 32'd9, 32'd11, 32'd13, 32'd15, 32'd17, 32'd19
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Zero and the modulus are fixed points of Park-Miller; never hand them to the core.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return ((s == 32'd0) || (s == PM_MODULUS)) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] pm_step(input logic [31:0] s);
    logic [63:0] p;
    p = {32'd0, s} * {32'd0, PM_A};
    return 32'(p % {32'd0, PM_MODULUS});
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin picker: first request after ptr, with wrap (rev 1.0)
`default_nettype none

module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] grant_o,
  output logic         any_o
);

  always_comb begin
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    grant_o = '0;
    any_o   = |req_i;
    // The last-granted requester is visited last, so it cannot starve others.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        grant_o = W'(idx);
        found   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/prng_arbiter.sv
// prng_arbiter -- shares one Park-Miller core between NREQ requesters, each with a private stream (rev 1.0)
`default_nettype none

module prng_arbiter
  import prng_pkg::*;
#(
  parameter int  NREQ    = 4,
  parameter int  TIMEOUT = 1024,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] rsp_valid,
  output logic [31:0]     rsp_data,
  input  logic            reseed,
  input  logic [IDW-1:0]  reseed_id,
  input  logic [31:0]     reseed_value,
  output logic            prng_start,
  output logic [31:0]     prng_seed,
  input  logic            prng_done,
  input  logic [31:0]     prng_rand,
  output logic            busy,
  output logic            err_timeout
);

  localparam int WDW = $clog2(TIMEOUT);

  state_e         state_q, state_d;
  logic [IDW-1:0] g_q, ptr_q, pick_g;
  logic           pick_any;
  logic [31:0]    seed_q, data_q;
  logic           armed_q, hit_q, err_q;
  logic [WDW-1:0] wdog_q;
  logic [31:0]    stream_q [NREQ];
  logic           rs_ok, rs_hit, wdog_expired;

  rr_pick #(.N(NREQ), .W(IDW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_g),
    .any_o   (pick_any)
  );

  assign rs_ok        = reseed && (int'(reseed_id) < NREQ);
  assign rs_hit       = rs_ok && (reseed_id == g_q);
  assign wdog_expired = (wdog_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    prng_start = 1'b0;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state_q)
      IDLE:  if (pick_any) state_d = ISSUE;
      ISSUE: begin
        prng_start     = 1'b1;
        req_ready[g_q] = 1'b1;
        state_d        = WAIT;
      end
      WAIT: begin
        if (prng_done && armed_q) state_d = RESP;
        else if (wdog_expired)    state_d = IDLE;
      end
      RESP: begin
        rsp_valid[g_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_q     <= '0;
      ptr_q   <= IDW'(NREQ - 1);
      seed_q  <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
      for (int i = 0; i < NREQ; i++) stream_q[i] <= DEFAULT_SEEDS[i];
    end else begin
      case (state_q)
        IDLE: if (pick_any) begin
          g_q    <= pick_g;
          seed_q <= stream_q[pick_g];
        end
        ISSUE: begin
          ptr_q   <= g_q;
          armed_q <= 1'b0;
          wdog_q  <= '0;
          hit_q   <= rs_hit;
        end
        WAIT: begin
          // A done seen before any done-low cycle is left over from the previous op.
          if (!prng_done) armed_q <= 1'b1;
          wdog_q <= wdog_q + 1'b1;
          if (prng_done && armed_q) data_q <= prng_rand;
          else if (wdog_expired)    err_q  <= 1'b1;
          if (rs_hit) hit_q <= 1'b1;
        end
        RESP: if (!hit_q && !rs_hit) stream_q[g_q] <= seed_fix(data_q);
        default: ;
      endcase
      if (rs_ok) stream_q[reseed_id] <= seed_fix({1'b0, reseed_value[30:0]});
    end
  end

  assign rsp_data    = data_q;
  assign prng_seed   = seed_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule

`default_nettype wire
